seq_player: RTL and testbench
=============================

SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 SHALL have parameter CH, default 4: number of output channels (LED lines, one-hot).
REQ-002 SHALL have parameter DEPTH, default 16: entries per sequence.
REQ-003 SHALL have parameter NSEQ, default 4: number of stored sequences.
REQ-004 SHALL have parameter TW, default 8: width of the timing inputs.
REQ-005 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous, active-low reset.
REQ-006 SHALL have ports: start in 1, request playback; seq_sel in clog2(NSEQ), sequence to play; round in clog2(DEPTH+1), number of entries to play.
REQ-007 SHALL have ports: on_cyc in TW, cycles each entry is shown; off_cyc in TW, blank cycles between entries.
REQ-008 SHALL have ports: leds out CH, current entry or zero; busy out 1, playback in progress; done out 1, one-cycle completion pulse; idx out clog2(DEPTH), entry being played.
REQ-009 SHALL have ports: rd_sel in clog2(NSEQ), rd_idx in clog2(DEPTH), rd_data out CH; this is a lookup port for answer checking.

Function
REQ-010 SHALL implement FSM states IDLE, SHOW, GAP, DONE.
REQ-011 IDLE with start=1 SHALL latch seq_sel, round, on_cyc and off_cyc, then enter SHOW at the next cycle with idx=0.
REQ-012 SHALL clamp a latched round of 0 to 1, and a round above DEPTH to DEPTH.
REQ-013 SHALL treat on_cyc=0 as 1; off_cyc=0 SHALL skip GAP entirely.
REQ-014 In SHOW, leds SHALL equal TABLE[sel][idx] (registered) for exactly on_cyc cycles.
REQ-015 In GAP, leds SHALL be 0 for exactly off_cyc cycles, then idx SHALL increment and the FSM SHALL return to SHOW.
REQ-016 After the SHOW of entry round-1, the FSM SHALL enter DONE directly, with no trailing GAP.
REQ-017 DONE SHALL last one cycle with done=1 and leds=0, then return to IDLE.
REQ-018 busy SHALL be 1 exactly in SHOW and GAP.
REQ-019 start SHALL be ignored in SHOW, GAP and DONE; mid-play changes to the latched inputs SHALL have no effect.
REQ-020 rd_data SHALL equal TABLE[rd_sel][rd_idx] one cycle after rd_sel/rd_idx are applied; this port SHALL be independent of the FSM.
REQ-021 idx SHALL never wrap; its maximum value is round-1.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately force IDLE, leds=0, busy=0, done=0, idx=0, rd_data=0 and clear all timers, including mid-playback.
REQ-023 The first accepted start SHALL be the first rising edge after rst_n deasserts.

Configuration
REQ-024 With SEQ_PLAYER_ABORT_EN defined, the block SHALL add input port abort (1 bit).
REQ-025 With SEQ_PLAYER_ABORT_EN, abort=1 in SHOW or GAP SHALL force IDLE at the next cycle, with leds=0, busy=0 and no done pulse.
REQ-026 With SEQ_PLAYER_ABORT_EN, abort=1 together with start in IDLE SHALL block start.
REQ-027 Without SEQ_PLAYER_ABORT_EN, the abort port and its logic SHALL be absent.

Structure
REQ-028 Shared package seq_pkg SHALL hold the defaults for CH, DEPTH and NSEQ, the FSM state enum, and the constant TABLE[NSEQ][DEPTH] of one-hot CH-bit entries.
REQ-029 TABLE sequence 0 SHALL be (hex): 1,4,2,8,1,8,4,8,2,8,1,2,8,1,4,2.
REQ-030 The table lookup SHALL be one sub-module, seq_rom, instantiated twice: once for playback and once for the rd port.
REQ-031 FSM and timers SHALL reside in seq_player.

Verification
REQ-032 Sequence 0 playback: sel=0, round=3, on=2, off=1, start at cycle T. Required: leds=0001 at T+1..T+2, 0 at T+3, 0100 at T+4..T+5, 0 at T+6, 0010 at T+7..T+8, done=1 at T+9, busy=0 at T+9.
REQ-033 Clamping: round=0 plays one entry (0001) then done; round=20 plays 16 entries, last=0010, with idx peaking at 15.
REQ-034 off=0 and on=1, round=4, sel=0: leds=1,4,2,8 on consecutive cycles, then done.
REQ-035 Start while busy, and changes to seq_sel/round mid-play, leave the output stream unchanged from the originally latched settings.
REQ-036 rst_n=0 pulsed during SHOW: all outputs 0 asynchronously, with no done pulse; a new start afterwards replays from idx 0.
REQ-037 With SEQ_PLAYER_ABORT_EN: abort during GAP returns to IDLE next cycle with done never asserted. Lookup check: rd_sel=0, rd_idx=5 gives rd_data=1000 one cycle later.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants, FSM state type and the LED pattern table for seq_player.
package seq_pkg;

  localparam int unsigned CH_DEF    = 4;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned NSEQ_DEF  = 4;

  // Index widths of the stored table itself.
  localparam int unsigned TBL_SW = $clog2(NSEQ_DEF);
  localparam int unsigned TBL_IW = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // One-hot LED patterns, one row per sequence.
  localparam logic [CH_DEF-1:0] SEQ_TABLE [NSEQ_DEF][DEPTH_DEF] = '{
    '{4'h1, 4'h4, 4'h2, 4'h8, 4'h1, 4'h8, 4'h4, 4'h8,
      4'h2, 4'h8, 4'h1, 4'h2, 4'h8, 4'h1, 4'h4, 4'h2},
    '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1,
      4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1},
    '{4'h2, 4'h1, 4'h8, 4'h4, 4'h4, 4'h2, 4'h1, 4'h8,
      4'h1, 4'h1, 4'h4, 4'h8, 4'h2, 4'h8, 4'h4, 4'h1},
    '{4'h4, 4'h8, 4'h1, 4'h2, 4'h8, 4'h2, 4'h4, 4'h1,
      4'h8, 4'h1, 4'h2, 4'h4, 4'h1, 4'h8, 4'h2, 4'h4}
  };

  // Port width helper that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_rom.sv
// Combinational pattern lookup; out-of-table addresses return all zeros.
module seq_rom
  import seq_pkg::*;
#(
  parameter  int unsigned CH    = CH_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned NSEQ  = NSEQ_DEF,
  localparam int unsigned SW    = clog2_min1(NSEQ),
  localparam int unsigned IW    = clog2_min1(DEPTH)
) (
  input  logic [SW-1:0] i_sel,
  input  logic [IW-1:0] i_idx,
  output logic [CH-1:0] o_data_c
);

  always_comb begin
    o_data_c = '0;
    if ((32'(i_sel) < NSEQ_DEF) && (32'(i_idx) < DEPTH_DEF)) begin
      o_data_c = CH'(SEQ_TABLE[TBL_SW'(i_sel)][TBL_IW'(i_idx)]);
    end
  end

endmodule

// File: rtl/seq_player.sv
// LED sequence player: shows table entries with on/off timing, plus a registered lookup port.
// Optional abort input is enabled with `define SEQ_PLAYER_ABORT_EN.
module seq_player
  import seq_pkg::*;
#(
  parameter  int unsigned CH    = CH_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  parameter  int unsigned NSEQ  = NSEQ_DEF,
  parameter  int unsigned TW    = 8,
  localparam int unsigned SW    = clog2_min1(NSEQ),
  localparam int unsigned IW    = clog2_min1(DEPTH),
  localparam int unsigned RW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef SEQ_PLAYER_ABORT_EN
  input  logic          abort,
`endif
  input  logic [SW-1:0] seq_sel,
  input  logic [RW-1:0] round,
  input  logic [TW-1:0] on_cyc,
  input  logic [TW-1:0] off_cyc,
  output logic [CH-1:0] leds,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] idx,
  input  logic [SW-1:0] rd_sel,
  input  logic [IW-1:0] rd_idx,
  output logic [CH-1:0] rd_data
);

  seq_state_e    r_state, w_state_nxt;
  logic [SW-1:0] r_sel, w_sel_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [IW-1:0] r_last, w_last_nxt;
  logic [TW-1:0] r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_on, w_on_nxt;
  logic [TW-1:0] r_off, w_off_nxt;
  logic [TW-1:0] w_on_eff;
  logic [CH-1:0] r_leds, w_leds_nxt, w_play_data;
  logic [CH-1:0] r_rd_data, w_rd_rom;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          w_start_ok;

  // Last entry index to play, with round clamped into 1..DEPTH.
  function automatic logic [IW-1:0] clamp_last(input logic [RW-1:0] r);
    if (r == '0) return '0;
    if (32'(r) > DEPTH) return IW'(DEPTH - 1);
    return IW'(r - RW'(1));
  endfunction

`ifdef SEQ_PLAYER_ABORT_EN
  assign w_start_ok = start & ~abort;
`else
  assign w_start_ok = start;
`endif

  assign w_on_eff = (on_cyc == '0) ? TW'(1) : on_cyc;

  // Next-state and timer logic; r_cnt holds remaining cycles of the current phase minus one.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_on_nxt    = r_on;
    w_off_nxt   = r_off;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_sel_nxt   = seq_sel;
          w_last_nxt  = clamp_last(round);
          w_on_nxt    = w_on_eff;
          w_off_nxt   = off_cyc;
          w_idx_nxt   = '0;
          w_cnt_nxt   = w_on_eff - TW'(1);
          w_state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - TW'(1);
        end else if (r_idx == r_last) begin
          w_state_nxt = ST_DONE;
        end else if (r_off == '0) begin
          w_idx_nxt = r_idx + IW'(1);
          w_cnt_nxt = r_on - TW'(1);
        end else begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = r_off - TW'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - TW'(1);
        end else begin
          w_state_nxt = ST_SHOW;
          w_idx_nxt   = r_idx + IW'(1);
          w_cnt_nxt   = r_on - TW'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
`ifdef SEQ_PLAYER_ABORT_EN
    if (abort && ((r_state == ST_SHOW) || (r_state == ST_GAP))) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end
`endif
  end

  // Outputs are registered from the next state so leds change on the same edge as the state.
  assign w_leds_nxt = (w_state_nxt == ST_SHOW) ? w_play_data : '0;
  assign w_busy_nxt = (w_state_nxt == ST_SHOW) || (w_state_nxt == ST_GAP);
  assign w_done_nxt = (w_state_nxt == ST_DONE);

  seq_rom #(
    .CH    (CH),
    .DEPTH (DEPTH),
    .NSEQ  (NSEQ)
  ) u_rom_play (
    .i_sel    (w_sel_nxt),
    .i_idx    (w_idx_nxt),
    .o_data_c (w_play_data)
  );

  seq_rom #(
    .CH    (CH),
    .DEPTH (DEPTH),
    .NSEQ  (NSEQ)
  ) u_rom_rd (
    .i_sel    (rd_sel),
    .i_idx    (rd_idx),
    .o_data_c (w_rd_rom)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_idx     <= '0;
      r_last    <= '0;
      r_cnt     <= '0;
      r_on      <= '0;
      r_off     <= '0;
      r_leds    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_idx     <= w_idx_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_on      <= w_on_nxt;
      r_off     <= w_off_nxt;
      r_leds    <= w_leds_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_rd_data <= w_rd_rom;
    end
  end

  assign leds    = r_leds;
  assign busy    = r_busy;
  assign done    = r_done;
  assign idx     = r_idx;
  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: per-cycle expectations queued at start, compared as the DUT plays.
module tb_seq_player;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] seq_sel;
  logic [4:0] round;
  logic [7:0] on_cyc;
  logic [7:0] off_cyc;
  logic [3:0] leds;
  logic       busy;
  logic       done;
  logic [3:0] idx;
  logic [1:0] rd_sel;
  logic [3:0] rd_idx;
  logic [3:0] rd_data;
`ifdef SEQ_PLAYER_ABORT_EN
  logic       abort;
`endif

  seq_player dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
`ifdef SEQ_PLAYER_ABORT_EN
    .abort   (abort),
`endif
    .seq_sel (seq_sel),
    .round   (round),
    .on_cyc  (on_cyc),
    .off_cyc (off_cyc),
    .leds    (leds),
    .busy    (busy),
    .done    (done),
    .idx     (idx),
    .rd_sel  (rd_sel),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] leds;
    logic       busy;
    logic       done;
    logic [3:0] idx;
    logic       idx_chk;
  } exp_t;

  exp_t       q[$];
  logic [3:0] seq0 [16] = '{4'h1, 4'h4, 4'h2, 4'h8, 4'h1, 4'h8, 4'h4, 4'h8,
                            4'h2, 4'h8, 4'h1, 4'h2, 4'h8, 4'h1, 4'h4, 4'h2};
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Expected cycle-by-cycle output of a sequence-0 playback.
  task automatic push_play(input int rnd, input int on, input int off);
    exp_t e;
    int   r;
    int   o;
    r = (rnd == 0) ? 1 : ((rnd > 16) ? 16 : rnd);
    o = (on == 0) ? 1 : on;
    for (int i = 0; i < r; i++) begin
      for (int c = 0; c < o; c++) begin
        e = '{leds: seq0[i], busy: 1'b1, done: 1'b0, idx: 4'(i), idx_chk: 1'b1};
        q.push_back(e);
      end
      if (i < r - 1) begin
        for (int c = 0; c < off; c++) begin
          e = '{leds: 4'h0, busy: 1'b1, done: 1'b0, idx: 4'(i), idx_chk: 1'b1};
          q.push_back(e);
        end
      end
    end
    e = '{leds: 4'h0, busy: 1'b0, done: 1'b1, idx: 4'h0, idx_chk: 1'b0};
    q.push_back(e);
    e = '{leds: 4'h0, busy: 1'b0, done: 1'b0, idx: 4'h0, idx_chk: 1'b0};
    q.push_back(e);
  endtask

  // Compare one queued entry per cycle; optionally disturb the inputs during the first cycles.
  task automatic drain(input string scen, input int disturb);
    exp_t e;
    int   k;
    k = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({scen, "/leds"}, 32'(leds), 32'(e.leds));
      chk({scen, "/busy"}, 32'(busy), 32'(e.busy));
      chk({scen, "/done"}, 32'(done), 32'(e.done));
      if (e.idx_chk) chk({scen, "/idx"}, 32'(idx), 32'(e.idx));
      if (k < disturb) begin
        start   = 1'b1;
        seq_sel = 2'd3;
        round   = 5'd1;
        on_cyc  = 8'd9;
        off_cyc = 8'd0;
      end else begin
        start = 1'b0;
      end
      k++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_play(input string scen, input int rnd, input int on, input int off,
                            input int disturb);
    push_play(rnd, on, off);
    start   = 1'b1;
    seq_sel = 2'd0;
    round   = 5'(rnd);
    on_cyc  = 8'(on);
    off_cyc = 8'(off);
    @(posedge clk);
    #1;
    drain(scen, disturb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b1;
    start   = 1'b0;
    seq_sel = '0;
    round   = '0;
    on_cyc  = '0;
    off_cyc = '0;
    rd_sel  = '0;
    rd_idx  = '0;
`ifdef SEQ_PLAYER_ABORT_EN
    abort   = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("reset/leds", 32'(leds), 32'h0);
    chk("reset/busy", 32'(busy), 32'h0);
    chk("reset/done", 32'(done), 32'h0);
    chk("reset/idx", 32'(idx), 32'h0);
    chk("reset/rd_data", 32'(rd_data), 32'h0);
    repeat (3) @(posedge clk);

    // Start presented together with reset release is taken on the first edge.
    @(negedge clk);
    rst_n = 1'b1;
    start_play("basic", 3, 2, 1, 0);

    @(negedge clk);
    start_play("round0", 0, 1, 1, 0);
    @(negedge clk);
    start_play("round20", 20, 1, 1, 0);
    @(negedge clk);
    start_play("off0", 4, 1, 0, 0);
    @(negedge clk);
    start_play("disturb", 3, 2, 1, 4);
    @(negedge clk);
    start_play("on0", 2, 0, 0, 0);

    // Lookup port: one-cycle latency, independent of the player.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_sel = 2'd0;
      rd_idx = 4'(i);
      #1;
      if (i > 0) chk("rd/hold", 32'(rd_data), 32'(seq0[i-1]));
      @(posedge clk);
      #1;
      chk($sformatf("rd/idx%0d", i), 32'(rd_data), 32'(seq0[i]));
    end
    @(negedge clk);
    rd_idx = 4'd5;
    @(posedge clk);
    #1;
    chk("rd/sel0_idx5", 32'(rd_data), 32'h8);

    // Asynchronous reset in the middle of a SHOW phase.
    @(negedge clk);
    start   = 1'b1;
    seq_sel = 2'd0;
    round   = 5'd3;
    on_cyc  = 8'd3;
    off_cyc = 8'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid/leds_pre", 32'(leds), 32'h1);
    chk("rstmid/busy_pre", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid/leds", 32'(leds), 32'h0);
    chk("rstmid/busy", 32'(busy), 32'h0);
    chk("rstmid/done", 32'(done), 32'h0);
    chk("rstmid/idx", 32'(idx), 32'h0);
    chk("rstmid/rd_data", 32'(rd_data), 32'h0);
    @(posedge clk);
    #1;
    chk("rstmid/done_hold", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_play("replay", 3, 2, 1, 0);

`ifdef SEQ_PLAYER_ABORT_EN
    // Abort during GAP, then abort blocking a start in IDLE.
    @(negedge clk);
    start   = 1'b1;
    seq_sel = 2'd0;
    round   = 5'd3;
    on_cyc  = 8'd2;
    off_cyc = 8'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("abort/leds0", 32'(leds), 32'h1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort/gap_leds", 32'(leds), 32'h0);
    chk("abort/gap_busy", 32'(busy), 32'h1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort/leds", 32'(leds), 32'h0);
    chk("abort/busy", 32'(busy), 32'h0);
    chk("abort/done", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("abort/no_done", 32'(done), 32'h0);
      chk("abort/idle_busy", 32'(busy), 32'h0);
    end
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort/blocked_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    chk("abort/blocked_busy2", 32'(busy), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
